// File: rtl/uart_rx.sv
// uart_rx -- receive half of the UART.
//
// Synchronises the asynchronous serial line, qualifies the start bit at its
// centre, samples 8 data bits LSB-first at bit centres, checks the stop bit
// and reports the result with a single-cycle strobe.
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_i         synchronous reset, active-high
//   rx_en         receiver enable, only looked at while idle
//   CLKS_PER_BIT  clk_i cycles per bit (4..65535), stable while busy
//   i_RX_Serial   asynchronous serial input, idle high
//   o_RX_Byte     last byte received with a good stop bit
//   o_RX_Done     one-cycle pulse: o_RX_Byte has just been updated
//   o_RX_Err      one-cycle pulse: stop bit was sampled low
//   o_RX_Busy     high whenever the receiver is not idle
//
// Handshake: o_RX_Done and o_RX_Err are single-cycle, mutually exclusive,
// unacknowledged strobes; there is no ready/back-pressure. Any consumer must
// capture o_RX_Byte in the cycle o_RX_Done is high (it is also held until the
// next good frame).

module uart_rx (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_en,
    input  logic [15:0] CLKS_PER_BIT,
    input  logic        i_RX_Serial,
    output logic [7:0]  o_RX_Byte,
    output logic        o_RX_Done,
    output logic        o_RX_Err,
    output logic        o_RX_Busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_CLEANUP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  byte_q, byte_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    logic        rx_s;
    logic [15:0] half;
    logic [15:0] last;

    assign rx_s = sync2_q;
    assign half = CLKS_PER_BIT >> 1;
    assign last = CLKS_PER_BIT - 16'd1;

    // Two-flop synchroniser; both flops reset to the idle (high) line level
    // so reset never looks like a start edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_RX_Serial;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            sh_q    <= 8'd0;
            byte_q  <= 8'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            byte_q  <= byte_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        byte_d  = byte_q;
        // Strobes default low so each one lasts exactly the cycle after it
        // is raised (that cycle is always CLEANUP).
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                idx_d = 3'd0;
                if (rx_en && !rx_s) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_q != half) begin
                    cnt_d = cnt_q + 16'd1;
                end else if (!rx_s) begin
                    // Still low at the start-bit centre: genuine start bit.
                    cnt_d   = 16'd0;
                    state_d = S_DATA;
                end else begin
                    // Line went back high: treat as a glitch, no strobe.
                    state_d = S_IDLE;
                end
            end

            S_DATA: begin
                if (cnt_q != last) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    sh_d[idx_q] = rx_s;
                    cnt_d       = 16'd0;
                    if (idx_q != 3'd7) begin
                        idx_d = idx_q + 3'd1;
                    end else begin
                        idx_d   = 3'd0;
                        state_d = S_STOP;
                    end
                end
            end

            S_STOP: begin
                if (cnt_q != last) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    if (rx_s) begin
                        byte_d = sh_q;
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    cnt_d   = 16'd0;
                    state_d = S_CLEANUP;
                end
            end

            S_CLEANUP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered alongside the state so busy tracks state_q exactly.
        busy_d = (state_d != S_IDLE);
    end

    assign o_RX_Byte = byte_q;
    assign o_RX_Done = done_q;
    assign o_RX_Err  = err_q;
    assign o_RX_Busy = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx. A driver task serialises frames on the
// line and pushes the expected strobe (kind, byte, cycle) into a queue; an
// independent monitor pops and compares whenever the DUT raises a strobe.
//
// Cycle bookkeeping: cyc counts rising edges. If the start bit is first
// captured at edge t, the strobe is set by edge t+HALF+9*C+3 and is seen at
// the following falling edge with cyc == t+HALF+9*C+3 (it occupies the clock
// cycle that ends at edge t+HALF+9*C+4).

module tb_uart_rx;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        rx_en;
    logic [15:0] CLKS_PER_BIT;
    logic        i_RX_Serial;
    logic [7:0]  o_RX_Byte;
    logic        o_RX_Done;
    logic        o_RX_Err;
    logic        o_RX_Busy;

    uart_rx dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_en        (rx_en),
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .i_RX_Serial  (i_RX_Serial),
        .o_RX_Byte    (o_RX_Byte),
        .o_RX_Done    (o_RX_Done),
        .o_RX_Err     (o_RX_Err),
        .o_RX_Busy    (o_RX_Busy)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int busy_hi = 0;
    always @(negedge clk_i) if (o_RX_Busy) busy_hi <= busy_hi + 1;

    // ---------------- scoreboard ----------------
    // entry = {is_err, expected o_RX_Byte, expected cyc}
    logic [40:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  last_good = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    logic        prev_strobe = 1'b0;
    logic [40:0] mon_e;

    always @(negedge clk_i) begin
        if (o_RX_Done && o_RX_Err) begin
            check("strobe_exclusive", {31'd0, o_RX_Done & o_RX_Err}, 32'd0);
        end
        if (o_RX_Done || o_RX_Err) begin
            if (prev_strobe) begin
                check("strobe_width", {31'd0, prev_strobe}, 32'd0);
            end
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {30'd0, o_RX_Done, o_RX_Err}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_kind_err", {31'd0, o_RX_Err}, {31'd0, mon_e[40]});
                check("rx_byte", {24'd0, o_RX_Byte}, {24'd0, mon_e[39:32]});
                check("strobe_cycle", cyc, mon_e[31:0]);
            end
        end
        prev_strobe <= o_RX_Done | o_RX_Err;
    end

    // ---------------- driver tasks ----------------
    // kind: 0 = no strobe expected, 1 = Done expected, 2 = Err expected.
    // abort_bit >= 0 pulses rst_i mid-way through that data bit and releases
    // the line high, ending the frame early.
    task automatic send_frame(input logic [7:0] b, input logic stop_val,
                              input int kind, input int abort_bit);
        int c;
        int t;
        int due;
        c = int'(CLKS_PER_BIT);
        i_RX_Serial = 1'b0;
        t   = cyc + 1;
        due = t + (c >> 1) + 9 * c + 3;
        if (kind == 1) begin
            exp_q.push_back({1'b0, b, due[31:0]});
            last_good = b;
        end else if (kind == 2) begin
            exp_q.push_back({1'b1, last_good, due[31:0]});
        end
        repeat (c) @(negedge clk_i);
        for (int k = 0; k < 8; k++) begin
            i_RX_Serial = b[k];
            if (k == abort_bit) begin
                repeat (c / 2) @(negedge clk_i);
                rst_i       = 1'b1;
                i_RX_Serial = 1'b1;
                @(negedge clk_i);
                rst_i     = 1'b0;
                last_good = 8'h00;
                return;
            end
            repeat (c) @(negedge clk_i);
        end
        i_RX_Serial = stop_val;
        repeat (c) @(negedge clk_i);
        i_RX_Serial = 1'b1;
    endtask

    task automatic idle(input int n);
        i_RX_Serial = 1'b1;
        repeat (n) @(negedge clk_i);
    endtask

    // ---------------- stimulus ----------------
    int busy_base;

    initial begin
        rst_i        = 1'b1;
        rx_en        = 1'b0;
        i_RX_Serial  = 1'b1;
        CLKS_PER_BIT = 16'd16;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        check("reset_byte", {24'd0, o_RX_Byte}, 32'h00);
        check("reset_done", {31'd0, o_RX_Done}, 32'd0);
        check("reset_err",  {31'd0, o_RX_Err},  32'd0);
        check("reset_busy", {31'd0, o_RX_Busy}, 32'd0);

        rx_en = 1'b1;

        // Nominal byte, C=16 (strobe 155 edges after capture).
        send_frame(8'hA5, 1'b1, 1, -1);
        idle(32);

        // Back-to-back, no idle gap between stop and next start.
        send_frame(8'h00, 1'b1, 1, -1);
        send_frame(8'hFF, 1'b1, 1, -1);
        idle(32);

        // Framing error: byte must stay at 0xFF, then a good 0x81.
        send_frame(8'h3C, 1'b0, 2, -1);
        idle(48);
        send_frame(8'h81, 1'b1, 1, -1);
        idle(32);

        // Glitch: 4-cycle low pulse is rejected at the start-bit centre.
        i_RX_Serial = 1'b0;
        repeat (4) @(negedge clk_i);
        i_RX_Serial = 1'b1;
        repeat (30) @(negedge clk_i);
        check("glitch_busy", {31'd0, o_RX_Busy}, 32'd0);
        send_frame(8'h3C, 1'b1, 1, -1);
        idle(32);

        // Receiver disabled: line activity is ignored entirely.
        rx_en     = 1'b0;
        busy_base = busy_hi;
        send_frame(8'h55, 1'b1, 0, -1);
        idle(32);
        check("disabled_busy_cycles", busy_hi - busy_base, 32'd0);
        rx_en = 1'b1;
        idle(4);

        // Reset during data bit 3: outputs back to reset values, no strobe.
        send_frame(8'h55, 1'b1, 0, 3);
        check("midrst_byte", {24'd0, o_RX_Byte}, 32'h00);
        check("midrst_busy", {31'd0, o_RX_Busy}, 32'd0);
        check("midrst_done", {31'd0, o_RX_Done}, 32'd0);
        check("midrst_err",  {31'd0, o_RX_Err},  32'd0);
        idle(16 * 12);

        // Divisor extremes.
        CLKS_PER_BIT = 16'd4;
        idle(4);
        send_frame(8'h96, 1'b1, 1, -1);
        idle(16);
        CLKS_PER_BIT = 16'd1000;
        idle(4);
        send_frame(8'h69, 1'b1, 1, -1);
        idle(2000);

        check("pending_expected", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Overall time bound.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete (cyc %0d)", cyc);
        n_bad = n_bad + 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

endmodule
